// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory,
// and queues {pc, instr} pairs for decode. Optional bound check: FETCH_BOUND_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_mem_q [DEPTH];
  logic [31:0]      pc_mem_d [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_pc_q, out_pc_d;
  logic [31:0]      out_instr_q, out_instr_d;

  logic        pop;
  logic        can_push;
  logic        push;
  logic [31:0] redirect_target;

  assign imem_addr       = pc_q;
  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_instr       = out_instr_q;
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  assign pop      = out_valid_q & out_ready;
  assign can_push = fetch_en & ~redirect_valid & ((count_q < FULL) | pop);

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  logic in_range;
  logic redirect_in_range;
  logic fault_q, fault_d;

  assign in_range          = {1'b0, pc_q} < MEM_BYTES;
  assign redirect_in_range = {1'b0, redirect_target} < MEM_BYTES;
  assign push              = can_push & in_range;
  assign fetch_fault       = fault_q;

  // Fault is sticky; only a redirect back into the memory clears it.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) begin
      fault_d = fault_q & ~redirect_in_range;
    end else if (can_push & ~in_range) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign push        = can_push;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect_valid) begin
      pc_d     = redirect_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = pc_q;
        instr_mem_d[wr_ptr_q] = imem_data;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        pc_d                  = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Outputs register the post-update head, so a fresh push is visible next cycle.
  always_comb begin
    out_valid_d = (count_d != '0);
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (out_valid_d) begin
      out_pc_d    = pc_mem_d[rd_ptr_d];
      out_instr_d = instr_mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PC_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirect, async reset,
// PC wrap and (when FETCH_BOUND_CHECK_EN is defined) the out-of-range fault.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data, out_instr, out_pc;
  logic        out_valid, fetch_fault;

  logic        rst_n_w, fetch_en_w, out_ready_w;
  logic [31:0] imem_addr_w, imem_data_w, out_instr_w, out_pc_w;
  logic        out_valid_w, fetch_fault_w;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_model(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0031_00B3;
      32'h0000_0004: return 32'h0030_8233;
      32'h0000_0008: return 32'h4012_02B3;
      default:       return 32'hC0DE_0000 | {16'h0000, addr[15:0]};
    endcase
  endfunction

  assign imem_data   = imem_model(imem_addr);
  assign imem_data_w = imem_model(imem_addr_w);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2), .MEM_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2), .MEM_WORDS(16)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .fetch_en(fetch_en_w), .imem_addr(imem_addr_w),
    .imem_data(imem_data_w), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_instr(out_instr_w),
    .out_pc(out_pc_w), .fetch_fault(fetch_fault_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst_n_w = 1'b0; fetch_en_w = 1'b0; out_ready_w = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst_addr_w", imem_addr_w, 32'hFFFF_FFFC);

    // Streaming from reset
    fetch_en = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
    tick();
    chk("s0_valid", {31'b0, out_valid}, 32'h1);
    chk("s0_pc", out_pc, 32'h0);
    chk("s0_instr", out_instr, 32'h0031_00B3);
    tick();
    chk("s1_pc", out_pc, 32'h4);
    chk("s1_instr", out_instr, 32'h0030_8233);
    tick();
    chk("s2_pc", out_pc, 32'h8);
    chk("s2_instr", out_instr, 32'h4012_02B3);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc", out_pc, 32'h0);
    tick();
    out_ready = 1'b0; rst_n = 1'b1;
    tick();
    chk("restart_valid", {31'b0, out_valid}, 32'h1);
    chk("restart_pc", out_pc, 32'h0);
    chk("restart_addr", imem_addr, 32'h4);
    tick();
    chk("fill_addr", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_addr", imem_addr, 32'h8);
      chk("full_instr", out_instr, 32'h0031_00B3);
      chk("full_pc", out_pc, 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("drain_pc4", out_pc, 32'h4);
    chk("drain_instr4", out_instr, 32'h0030_8233);
    tick();
    chk("drain_pc8", out_pc, 32'h8);
    chk("drain_instr8", out_instr, 32'h4012_02B3);

    // Redirect while full; simultaneous pop must be discarded
    out_ready = 1'b0;
    tick();
    chk("pre_redir_addr", imem_addr, 32'h10);
    chk("pre_redir_pc", out_pc, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h6; out_ready = 1'b1;
    tick();
    chk("redir_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h4);
    redirect_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("redir_tgt_valid", {31'b0, out_valid}, 32'h1);
    chk("redir_tgt_pc", out_pc, 32'h4);
    chk("redir_tgt_instr", out_instr, 32'h0030_8233);

    // fetch_en low: PC holds while the queue drains
    fetch_en = 1'b0; out_ready = 1'b1;
    tick();
    chk("hold_valid", {31'b0, out_valid}, 32'h0);
    chk("hold_addr", imem_addr, 32'h8);
    tick();
    chk("hold_addr2", imem_addr, 32'h8);

    // Run toward the end of the memory
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h30;
    tick();
    chk("end_redir_addr", imem_addr, 32'h30);
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("end_pc", out_pc, 32'h30 + 32'(k) * 32'd4);
    end
    chk("end_addr40", imem_addr, 32'h40);
    chk("end_fault_pre", {31'b0, fetch_fault}, 32'h0);
    tick();
`ifdef FETCH_BOUND_CHECK_EN
    chk("bound_fault", {31'b0, fetch_fault}, 32'h1);
    chk("bound_valid", {31'b0, out_valid}, 32'h0);
    chk("bound_addr", imem_addr, 32'h40);
    tick();
    chk("bound_sticky", {31'b0, fetch_fault}, 32'h1);
    chk("bound_addr2", imem_addr, 32'h40);
`else
    chk("past_end_pc", out_pc, 32'h40);
    chk("past_end_instr", out_instr, 32'hC0DE_0040);
    chk("past_end_fault", {31'b0, fetch_fault}, 32'h0);
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    chk("clr_fault", {31'b0, fetch_fault}, 32'h0);
    chk("clr_addr", imem_addr, 32'h0);
    redirect_valid = 1'b0;

    // PC wrap from RESET_PC = 0xFFFFFFFC
    fetch_en_w = 1'b1; out_ready_w = 1'b1; rst_n_w = 1'b1;
    tick();
`ifdef FETCH_BOUND_CHECK_EN
    chk("wrap_oob_valid", {31'b0, out_valid_w}, 32'h0);
    tick();
    chk("wrap_oob_fault", {31'b0, fetch_fault_w}, 32'h1);
    chk("wrap_oob_addr", imem_addr_w, 32'hFFFF_FFFC);
`else
    chk("wrap_pc0", out_pc_w, 32'hFFFF_FFFC);
    chk("wrap_instr0", out_instr_w, 32'hC0DE_FFFC);
    tick();
    chk("wrap_pc1", out_pc_w, 32'h0);
    chk("wrap_instr1", out_instr_w, 32'h0031_00B3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
